// File: rtl/hub75_scan.sv
// hub75_scan: scan controller for a 64x32 HUB75 LED panel (1/16 scan, two
// half-panels driven in parallel).
//
// Each row pair is prepared, shifted out 64 columns (one sclk pulse per
// column), blanked, latched, and then displayed for ON_CYCLES clocks. A full
// frame is 16 row pairs; frame_done pulses once when the last row finishes.
//
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   enable          : scanning runs while high; a frame in progress always
//                     completes before the block returns to idle
//   x, y1, y2       : registered frame-buffer read address (y2 = y1 + 16)
//   c1, c2          : frame-buffer colour for (x,y1) and (x,y2), {B,G,R}
//   r1..b2          : registered panel colour data, upper and lower halves
//   sclk, lat, oe_n : panel shift clock, latch strobe, active-low enable
//   addr            : panel row-pair address
//   frame_done      : one-cycle pulse at the end of each frame
module hub75_scan #(
  parameter int ON_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [5:0] x,
  output logic [4:0] y1,
  output logic [4:0] y2,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  output logic       r1,
  output logic       g1,
  output logic       b1,
  output logic       r2,
  output logic       g2,
  output logic       b2,
  output logic       sclk,
  output logic       lat,
  output logic       oe_n,
  output logic [3:0] addr,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SHIFT_LO,
    SHIFT_HI,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  localparam logic [15:0] ON_LAST = 16'(ON_CYCLES - 1);

  state_t      state;
  logic [3:0]  row;
  logic [5:0]  col;
  logic [15:0] on_cnt;

  // Every output is registered and updated on entry to the state that owns
  // it, so each state's outputs are valid for its whole duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= 4'd0;
      col        <= 6'd0;
      on_cnt     <= 16'd0;
      x          <= 6'd0;
      y1         <= 5'd0;
      y2         <= 5'd16;
      {b1, g1, r1} <= 3'b000;
      {b2, g2, r2} <= 3'b000;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      addr       <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          oe_n <= 1'b1;
          sclk <= 1'b0;
          lat  <= 1'b0;
          if (enable) begin
            row   <= 4'd0;
            col   <= 6'd0;
            x     <= 6'd0;
            y1    <= 5'd0;
            y2    <= 5'd16;
            state <= PREP;
          end
        end

        // The frame buffer has had a full cycle to answer for column 0.
        PREP: begin
          {b1, g1, r1} <= c1;
          {b2, g2, r2} <= c2;
          sclk  <= 1'b0;
          state <= SHIFT_LO;
        end

        // Raise sclk on the stable colour and already ask for the next column.
        SHIFT_LO: begin
          sclk  <= 1'b1;
          x     <= col + 6'd1;
          state <= SHIFT_HI;
        end

        SHIFT_HI: begin
          sclk <= 1'b0;
          if (col == 6'd63) begin
            addr  <= row;
            oe_n  <= 1'b1;
            state <= BLANK;
          end else begin
            col          <= col + 6'd1;
            {b1, g1, r1} <= c1;
            {b2, g2, r2} <= c2;
            state        <= SHIFT_LO;
          end
        end

        BLANK: begin
          lat   <= 1'b1;
          oe_n  <= 1'b1;
          state <= LATCH;
        end

        LATCH: begin
          lat    <= 1'b0;
          oe_n   <= 1'b0;
          on_cnt <= 16'd0;
          state  <= DISPLAY;
        end

        // enable is only consulted at frame end so a frame is never cut short.
        DISPLAY: begin
          if (on_cnt == ON_LAST) begin
            oe_n <= 1'b1;
            col  <= 6'd0;
            x    <= 6'd0;
            if (row == 4'd15) begin
              frame_done <= 1'b1;
              row        <= 4'd0;
              y1         <= 5'd0;
              y2         <= 5'd16;
              state      <= enable ? PREP : IDLE;
            end else begin
              row   <= row + 4'd1;
              y1    <= {1'b0, row + 4'd1};
              y2    <= {1'b1, row + 4'd1};
              state <= PREP;
            end
          end else begin
            on_cnt <= on_cnt + 16'd1;
          end
        end

        default: begin
          oe_n  <= 1'b1;
          sclk  <= 1'b0;
          lat   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: self-checking bench for hub75_scan.
//
// Two instances share clock, reset and enable: dut (ON_CYCLES=4) carries the
// main checks, dut_b (ON_CYCLES=1) is watched only for display width and row
// period. The frame buffer is modelled as c1 = x[2:0], c2 = ~x[2:0].
module tb_hub75_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic enable;

  logic [5:0] x;
  logic [4:0] y1, y2;
  logic [2:0] c1, c2;
  logic       r1, g1, b1, r2, g2, b2, sclk, lat, oe_n, frame_done;
  logic [3:0] addr;

  logic [5:0] x_b;
  logic [4:0] y1_b, y2_b;
  logic [2:0] c1_b, c2_b;
  logic       r1_b, g1_b, b1_b, r2_b, g2_b, b2_b, sclk_b, lat_b, oe_n_b, frame_done_b;
  logic [3:0] addr_b;

  assign c1   = x[2:0];
  assign c2   = ~x[2:0];
  assign c1_b = x_b[2:0];
  assign c2_b = ~x_b[2:0];

  hub75_scan #(.ON_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .x(x), .y1(y1), .y2(y2), .c1(c1), .c2(c2),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .addr(addr), .frame_done(frame_done)
  );

  hub75_scan #(.ON_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .x(x_b), .y1(y1_b), .y2(y2_b), .c1(c1_b), .c2(c2_b),
    .r1(r1_b), .g1(g1_b), .b1(b1_b), .r2(r2_b), .g2(g2_b), .b2(b2_b),
    .sclk(sclk_b), .lat(lat_b), .oe_n(oe_n_b), .addr(addr_b), .frame_done(frame_done_b)
  );

  // Expected per-row activity for a complete row with ON_CYCLES=4.
  typedef struct {
    int row;
    int edges;
    int lats;
    int lat_addr;
    int oe_low;
    int oe_falls;
  } row_vec_t;

  row_vec_t tbl[16];

  int total_checks = 0;
  int pass_checks  = 0;

  // Per-row logs for dut, indexed by y1 and cleared when epoch changes.
  int edge_cnt[16];
  int lat_cnt[16];
  int lat_addr_log[16];
  int oe_low[16];
  int oe_falls[16];
  int colour_bad   = 0;
  int lat_bad      = 0;
  int y_bad        = 0;
  int epoch        = 0;
  int seen_epoch   = -1;
  int log_frames   = 0;
  int fd_count     = 0;
  int fd_time[$];
  int oe_low_total = 0;
  int cyc          = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_oe   = 1'b1;
  logic [2:0] prev_col1 = 3'b000;
  logic [2:0] prev_col2 = 3'b000;

  // dut_b display-width / row-period monitor.
  logic mon_b_on   = 1'b0;
  int   cyc_b      = 0;
  int   last_fall  = -1;
  int   run_b      = 0;
  int   runs_ok    = 0;
  int   bad_runs   = 0;
  int   periods_ok = 0;
  int   bad_period = 0;
  logic prev_oe_b  = 1'b1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) pass_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic rn);
    @(negedge clk);
    enable = en;
    rst_n  = rn;
  endtask

  task automatic checkRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      checkOutput($sformatf("row%0d_sclk_edges", tbl[i].row), edge_cnt[tbl[i].row], tbl[i].edges);
      checkOutput($sformatf("row%0d_lat_pulses", tbl[i].row), lat_cnt[tbl[i].row], tbl[i].lats);
      checkOutput($sformatf("row%0d_lat_addr", tbl[i].row), lat_addr_log[tbl[i].row], tbl[i].lat_addr);
      checkOutput($sformatf("row%0d_oe_low", tbl[i].row), oe_low[tbl[i].row], tbl[i].oe_low);
      checkOutput($sformatf("row%0d_oe_runs", tbl[i].row), oe_falls[tbl[i].row], tbl[i].oe_falls);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_oe_n"}, int'(oe_n), 1);
    checkOutput({tag, "_sclk"}, int'(sclk), 0);
    checkOutput({tag, "_lat"}, int'(lat), 0);
    checkOutput({tag, "_colours"}, int'({b2, g2, r2, b1, g1, r1}), 0);
    checkOutput({tag, "_addr"}, int'(addr), 0);
    checkOutput({tag, "_x"}, int'(x), 0);
    checkOutput({tag, "_y1"}, int'(y1), 0);
    checkOutput({tag, "_y2"}, int'(y2), 16);
    checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Logs dut activity into per-row buckets until the frame_done that ends
  // the current logging epoch.
  always @(negedge clk) begin
    int r;
    cyc++;
    r = int'(y1[3:0]);
    if (epoch != seen_epoch) begin
      for (int i = 0; i < 16; i++) begin
        edge_cnt[i] = 0; lat_cnt[i] = 0; lat_addr_log[i] = -1;
        oe_low[i] = 0; oe_falls[i] = 0;
      end
      seen_epoch = epoch;
      log_frames = 0;
    end
    if (y2 != y1 + 5'd16 || y1 > 5'd15) y_bad++;
    if (frame_done) begin
      fd_count++;
      fd_time.push_back(cyc);
      log_frames++;
    end else if (log_frames == 0) begin
      if (sclk && !prev_sclk) begin
        if ({b1, g1, r1} != 3'(edge_cnt[r]) || {b2, g2, r2} != ~3'(edge_cnt[r]) ||
            {b1, g1, r1} != prev_col1 || {b2, g2, r2} != prev_col2)
          colour_bad++;
        edge_cnt[r]++;
      end
      if (lat) begin
        lat_cnt[r]++;
        lat_addr_log[r] = int'(addr);
        if (!oe_n) lat_bad++;
      end
      if (!oe_n) oe_low[r]++;
      if (!oe_n && prev_oe) oe_falls[r]++;
    end
    if (!oe_n) oe_low_total++;
    prev_sclk = sclk;
    prev_oe   = oe_n;
    prev_col1 = {b1, g1, r1};
    prev_col2 = {b2, g2, r2};
  end

  // dut_b: each display window must be one cycle, rows 132 cycles apart.
  always @(negedge clk) begin
    cyc_b++;
    if (!mon_b_on) begin
      last_fall = -1;
      run_b     = 0;
    end else begin
      if (!oe_n_b) run_b++;
      if (!oe_n_b && prev_oe_b) begin
        if (last_fall >= 0) begin
          if (cyc_b - last_fall == 132) periods_ok++;
          else bad_period++;
        end
        last_fall = cyc_b;
      end
      if (oe_n_b && !prev_oe_b) begin
        if (run_b == 1) runs_ok++;
        else bad_runs++;
        run_b = 0;
      end
    end
    prev_oe_b = oe_n_b;
  end

  initial begin
    int period;
    int snap_fd;
    int snap_oe;
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = '{i, 64, 1, i, 4, 1};

    repeat (3) @(negedge clk);
    checkResetValues("reset");

    applyStimulus(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("idle_oe_n", int'(oe_n), 1);
    checkOutput("idle_sclk", int'(sclk), 0);

    // Full frames with continuous enable; first cycles checked by hand.
    epoch++;
    mon_b_on = 1'b1;
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("prep_sclk", int'(sclk), 0);
    checkOutput("prep_y1", int'(y1), 0);
    checkOutput("prep_y2", int'(y2), 16);
    @(negedge clk);
    checkOutput("shift_lo_c2", int'({b2, g2, r2}), 7);
    checkOutput("shift_lo_sclk", int'(sclk), 0);
    @(negedge clk);
    checkOutput("shift_hi_sclk", int'(sclk), 1);
    checkOutput("shift_hi_x", int'(x), 1);

    for (int i = 0; i < 5000 && fd_count < 2; i++) @(negedge clk);
    checkOutput("frames_done", fd_count, 2);
    period = (fd_time.size() >= 2) ? fd_time[1] - fd_time[0] : -1;
    checkOutput("frame_period", period, 2160);
    checkRows(0, 15);
    checkOutput("colour_errors", colour_bad, 0);
    checkOutput("lat_while_oe_low", lat_bad, 0);
    checkOutput("y_range_errors", y_bad, 0);

    mon_b_on = 1'b0;
    checkOutput("on1_bad_width", bad_runs, 0);
    checkOutput("on1_bad_period", bad_period, 0);
    checkOutput("on1_width_seen", int'(runs_ok >= 20), 1);
    checkOutput("on1_period_seen", int'(periods_ok >= 20), 1);

    // Drop enable during row 7: the frame still completes, then idles.
    for (int i = 0; i < 1500 && y1 != 5'd7; i++) @(negedge clk);
    checkOutput("reach_row7", int'(y1), 7);
    epoch++;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 2500 && fd_count < 3; i++) @(negedge clk);
    checkOutput("frames_after_drop", fd_count, 3);
    checkRows(8, 15);
    snap_fd = fd_count;
    snap_oe = oe_low_total;
    repeat (300) @(negedge clk);
    checkOutput("idle_no_frame_done", fd_count, snap_fd);
    checkOutput("idle_no_display", oe_low_total - snap_oe, 0);
    checkOutput("idle_after_drop_oe_n", int'(oe_n), 1);
    checkOutput("idle_after_drop_sclk", int'(sclk), 0);

    // Reset during SHIFT_HI of row 5, column 30 (x already points at 31).
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 1500 && !(y1 == 5'd5 && sclk && x == 6'd31); i++) @(negedge clk);
    checkOutput("reach_row5_col30", int'(y1 == 5'd5 && sclk && x == 6'd31), 1);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checkResetValues("async_reset");
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    epoch++;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10 && !sclk; i++) @(negedge clk);
    checkOutput("restart_sclk", int'(sclk), 1);
    checkOutput("restart_y1", int'(y1), 0);
    checkOutput("restart_y2", int'(y2), 16);
    checkOutput("restart_c1", int'({b1, g1, r1}), 0);
    repeat (200) @(negedge clk);
    checkOutput("restart_row0_edges", edge_cnt[0], 64);
    checkOutput("restart_row0_lat", lat_cnt[0], 1);
    checkOutput("restart_row0_addr", lat_addr_log[0], 0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 256, setting the display-on time per row in clocks (legal 1..65535).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1: run scanning while high.
REQ-005 The block SHALL have ports x (output, 6) and y1/y2 (outputs, 5 each): registered pixel address to the frame buffer.
REQ-006 The block SHALL have ports c1 and c2, inputs, 3 each: frame-buffer pixel colour for (x,y1) and (x,y2), combinational from address; bit0=R, bit1=G, bit2=B.
REQ-007 The block SHALL have ports r1, g1, b1, r2, g2, b2 (outputs, 1 each): registered panel colour data.
REQ-008 The block SHALL have ports sclk, lat, oe_n (outputs, 1 each): panel shift clock, latch strobe and active-low output enable.
REQ-009 The block SHALL have port addr, output, 4: panel row-pair address.
REQ-010 The block SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame.

Function
REQ-011 The FSM SHALL have states IDLE, PREP, SHIFT_LO, SHIFT_HI, BLANK, LATCH and DISPLAY.
REQ-012 The FSM SHALL go IDLE->PREP when enable=1, with row=0 and col=0.
REQ-013 PREP (1 cycle): x=0, y1=row, y2=row+16; go to SHIFT_LO.
REQ-014 Entry into SHIFT_LO: {b1,g1,r1}<=c1 and {b2,g2,r2}<=c2 for the current x; sclk=0 throughout SHIFT_LO.
REQ-015 Entry into SHIFT_HI: sclk=1; x<=col+1 (wraps to 0 after 63); colour outputs held stable.
REQ-016 SHIFT_HI SHALL return to SHIFT_LO for col<63 and go to BLANK after col 63, giving exactly 64 sclk rising edges per row.
REQ-017 BLANK (1 cycle): oe_n=1, sclk=0, addr<=row.
REQ-018 LATCH (1 cycle): lat=1, oe_n=1; lat SHALL be 0 in every other state.
REQ-019 DISPLAY: oe_n=0 for exactly ON_CYCLES cycles, counted by an internal counter; oe_n SHALL be 1 in every other state.
REQ-020 On DISPLAY exit, row 0..14 SHALL increment row and go to PREP.
REQ-021 On DISPLAY exit, row 15 SHALL pulse frame_done for 1 cycle and set row=0, then go to PREP if enable=1, else to IDLE.
REQ-022 Row time SHALL be 131+ON_CYCLES clocks (1 PREP + 128 shift + 1 BLANK + 1 LATCH + ON_CYCLES) and frame time 16x that.
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; scanning stops only at frame end.
REQ-024 y2 SHALL always equal y1+16; y1 SHALL stay within 0..15.
REQ-025 In IDLE: oe_n=1, sclk=0, lat=0; colour outputs and addr hold.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, oe_n=1, sclk=0, lat=0, all colour outputs=0, addr=0, x=0, y1=0, y2=16, frame_done=0, and all counters=0.
REQ-027 Reset assertion mid-operation (any state) SHALL abandon the row with the panel blanked (oe_n=1).
REQ-028 After rst_n rises, the block SHALL restart from row 0 col 0 on the first enable=1 edge.

Verification (ON_CYCLES=4 unless stated)
REQ-029 Bench case: frame buffer model c1=x[2:0], c2=~x[2:0], enable=1 -> 64 sclk rising edges per row; on the k-th edge {b1,g1,r1}=k[2:0] and {b2,g2,r2}=~k[2:0], stable over each sclk high phase.
REQ-030 Bench case: run a full frame -> addr steps 0..15 with one lat pulse per row, each occurring while oe_n=1.
REQ-031 Bench case: run a full frame -> oe_n low for 4 consecutive cycles per row and frame_done pulses every 2160 cycles.
REQ-032 Bench case: drop enable at row 7 -> rows 8..15 still complete, frame_done pulses once, then IDLE with oe_n=1.
REQ-033 Bench case: assert rst_n low during SHIFT_HI of row 5 col 30 -> outputs take reset values asynchronously; after release and re-enable, first row scanned is y1=0, y2=16.
REQ-034 Bench case: ON_CYCLES=1 -> oe_n low exactly 1 cycle per row and row period 132 cycles.
